// File: rtl/bus_arbiter.sv
// Two-master (CPU/DMA) arbiter and 8085-style bus sequencer running T1/T2/Tw/T3
// with programmable wait states and MEM_READY stretching; all flops switch on the falling clock edge.
module bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_in,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_io_mn,
    input  logic [15:0] cpu_add,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_ready,
    output logic [7:0]  cpu_din,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic        dma_io_mn,
    input  logic [15:0] dma_add,
    input  logic [7:0]  dma_dout,
    output logic        dma_ready,
    output logic [7:0]  dma_din,
    output logic [1:0]  grant,
    output logic [15:0] ADD,
    output logic [7:0]  DATA_OUT,
    output logic        DATA_OE,
    input  logic [7:0]  DATA_IN,
    output logic        RDn,
    output logic        WRn,
    output logic        IO_Mn,
    input  logic        MEM_READY,
    output logic [2:0]  bus_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_STROBE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        last_dma, last_n;
    logic        wr_q, wr_n;
    logic        pick_dma;
    logic [1:0]  grant_n;
    logic [15:0] add_n;
    logic [7:0]  dout_n, cpu_din_n, dma_din_n;
    logic        oe_n, rdn_n, wrn_n, io_n, cpu_rdy_n, dma_rdy_n;

    assign bus_state = state;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_n    = last_dma;
        wr_n      = wr_q;
        grant_n   = grant;
        add_n     = ADD;
        dout_n    = DATA_OUT;
        oe_n      = DATA_OE;
        rdn_n     = RDn;
        wrn_n     = WRn;
        io_n      = IO_Mn;
        cpu_rdy_n = 1'b0;
        dma_rdy_n = 1'b0;
        cpu_din_n = cpu_din;
        dma_din_n = dma_din;
        // DMA wins when alone, or on a tie when the CPU was served last
        pick_dma  = dma_req && (!cpu_req || !last_dma);

        case (state)
            S_IDLE: begin
                grant_n = '0;
                if (cpu_req || dma_req) begin
                    state_n = S_ADDR;
                    grant_n = pick_dma ? 2'b10 : 2'b01;
                    add_n   = pick_dma ? dma_add   : cpu_add;
                    dout_n  = pick_dma ? dma_dout  : cpu_dout;
                    io_n    = pick_dma ? dma_io_mn : cpu_io_mn;
                    wr_n    = pick_dma ? dma_wr    : cpu_wr;
                    oe_n    = pick_dma ? dma_wr    : cpu_wr;
                end
            end
            S_ADDR: begin
                state_n = S_STROBE;
                rdn_n   = wr_q;
                wrn_n   = !wr_q;
                cnt_n   = 4'(WAIT_CYCLES);
            end
            S_STROBE, S_WAIT: begin
                // STROBE and WAIT share the countdown; a zero count with MEM_READY ends the access
                state_n = S_WAIT;
                if (cnt != '0) begin
                    cnt_n = cnt - 4'd1;
                end else if (MEM_READY) begin
                    state_n = S_DONE;
                    rdn_n   = 1'b1;
                    wrn_n   = 1'b1;
                    oe_n    = 1'b0;
                    last_n  = grant[1];
                    if (grant[1]) begin
                        dma_rdy_n = 1'b1;
                        if (!wr_q) dma_din_n = DATA_IN;
                    end else begin
                        cpu_rdy_n = 1'b1;
                        if (!wr_q) cpu_din_n = DATA_IN;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                grant_n = '0;
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(negedge clock or posedge reset_in) begin
        if (reset_in) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last_dma  <= 1'b1;
            wr_q      <= 1'b0;
            grant     <= '0;
            ADD       <= '0;
            DATA_OUT  <= '0;
            DATA_OE   <= 1'b0;
            RDn       <= 1'b1;
            WRn       <= 1'b1;
            IO_Mn     <= 1'b0;
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
            cpu_din   <= '0;
            dma_din   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last_dma  <= last_n;
            wr_q      <= wr_n;
            grant     <= grant_n;
            ADD       <= add_n;
            DATA_OUT  <= dout_n;
            DATA_OE   <= oe_n;
            RDn       <= rdn_n;
            WRn       <= wrn_n;
            IO_Mn     <= io_n;
            cpu_ready <= cpu_rdy_n;
            dma_ready <= dma_rdy_n;
            cpu_din   <= cpu_din_n;
            dma_din   <= dma_din_n;
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master bus sequencer and arbiter sharing one external 8085-style memory/IO bus between the CPU core and a DMA engine. It grants the bus per access (round-robin on contention), runs the T1/T2/Tw/T3 strobe sequence with a programmable wait-state count plus external READY stretching, and returns read data with a one-cycle ready pulse to the owning master.

## Interface
- WAIT_CYCLES, 2: fixed wait states per access, 0..15 (4-bit counter).
- clock  in  1  system clock; all flops switch on the falling edge, as the CPU core does.
- reset_in  in  1  asynchronous, active-high reset.
- cpu_req / dma_req  in  1  access request; held high until the master's ready pulse.
- cpu_wr / dma_wr  in  1  1 = write, 0 = read.
- cpu_io_mn / dma_io_mn  in  1  1 = IO space, 0 = memory.
- cpu_add / dma_add  in  16  access address.
- cpu_dout / dma_dout  in  8  write data.
- cpu_ready / dma_ready  out  1  one-cycle completion pulse to the owner.
- cpu_din / dma_din  out  8  read data; valid while the matching ready is high, held until the next read by that master.
- grant  out  2  one-hot owner, bit0 = CPU, bit1 = DMA; 00 when idle.
- ADD  out  16  bus address.
- DATA_OUT  out  8  bus write data.
- DATA_OE  out  1  write-data drive enable.
- DATA_IN  in  8  bus read data.
- RDn / WRn  out  1  active-low read/write strobes.
- IO_Mn  out  1  bus space select.
- MEM_READY  in  1  device ready; low stretches the access.
- bus_state  out  3  debug: IDLE=0, ADDR=1, STROBE=2, WAIT=3, DONE=4.

## Operation
- All outputs registered. Reset values: bus_state IDLE, grant 00, ADD 0000, DATA_OUT 00, DATA_OE 0, RDn 1, WRn 1, IO_Mn 0, cpu_ready/dma_ready 0, cpu_din/dma_din 00. The last-served pointer resets to DMA, so the CPU wins the first tie.
- IDLE: with no request, remain in IDLE. A single request wins. When both are requesting, the master not served last wins. The winner is latched into grant; the state moves to ADDR.
- ADDR (T1): latch the winner's add/wr/io_mn/dout into ADD/IO_Mn/DATA_OUT. Strobes stay high. DATA_OE=1 on writes. Next state is STROBE.
- STROBE (T2): drive RDn=0 (read) or WRn=0 (write) and load the wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES=0 and MEM_READY=1, go to DONE.
  - Otherwise go to WAIT.
- WAIT: the counter decrements each cycle. When the counter is 0 at the edge and MEM_READY=1, go to DONE. When MEM_READY=0, stay in WAIT and the counter holds at 0.
- DONE (T3):
  - On reads, DATA_IN is captured into the owner's din at the edge entering DONE.
  - Strobes return high, DATA_OE=0.
  - The owner's ready is 1 for exactly this cycle; the last-served pointer is updated.
  - Next state is IDLE, where grant returns to 00.
- The master's signals are sampled only in IDLE (req) and ADDR (payload). Later changes are ignored. If req drops mid-access, the access still completes and the ready pulse is still issued.
- Back-to-back accesses: a master keeping req high in the IDLE after its DONE starts a new access. When both request, that master loses to the other.
- The non-owner's ready is never asserted. RDn and WRn are never low together.

## Timing
- With req high in IDLE cycle n:
  - ADDR in cycle n+1.
  - STROBE in n+2.
  - WAIT in n+3 .. n+2+W (W = WAIT_CYCLES).
  - DONE with ready high in n+3+W.
  - IDLE in n+4+W.
- Each MEM_READY-low sample in the last WAIT cycle adds one cycle. Minimum access is 4 cycles (W=0, MEM_READY=1).
- Strobe low width is 1+W cycles, plus stretch.
- The address is stable from ADDR through DONE. DATA_OUT is stable ADDR..DONE on writes.
- Reset mid-access: state goes to IDLE immediately (asynchronous), strobes go high and grant goes to 00. No ready pulse is issued, and the aborted access is not retried.

## Test plan
- Reset then CPU read, W=2, addr 0502, DATA_IN=3E: ADD=0502, IO_Mn=0, RDn low for 3 cycles, cpu_ready pulses in cycle n+5 with cpu_din=3E, grant=01 during the access, dma_ready stays 0.
- DMA IO write, addr 0040, data A5, W=0: WRn low for 1 cycle, DATA_OE=1 from ADDR through STROBE, IO_Mn=1, dma_ready in cycle n+3.
- Both req high in the same IDLE, both held for 4 accesses: grants alternate CPU, DMA, CPU, DMA. Each pair is separated by an IDLE cycle.
- MEM_READY held low for 3 cycles during the last WAIT with W=1: ready is delayed by exactly 3 cycles and RDn stays low for 5 cycles.
- reset_in pulsed during STROBE of a CPU write: WRn=1 and grant=00 immediately, no cpu_ready, and the next access starts cleanly from IDLE.
- cpu_req dropped in ADDR: the access completes with the originally latched address, and cpu_ready pulses once.
